// File: rtl/qos_wrr_scheduler.sv
// qos_wrr_scheduler: weighted round-robin drain of four QoS class FIFOs onto one link FIFO
module qos_wrr_scheduler #(
  parameter int DATA_W   = 12,
  parameter int WEIGHT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic [WEIGHT_W-1:0] weight0,
  input  logic [WEIGHT_W-1:0] weight1,
  input  logic [WEIGHT_W-1:0] weight2,
  input  logic [WEIGHT_W-1:0] weight3,
  input  logic [3:0]          fifo_empty,
  input  logic [DATA_W-1:0]   fifo_data0,
  input  logic [DATA_W-1:0]   fifo_data1,
  input  logic [DATA_W-1:0]   fifo_data2,
  input  logic [DATA_W-1:0]   fifo_data3,
  input  logic                almost_full_out,
  output logic [3:0]          pop,
  output logic                push_out,
  output logic [DATA_W-1:0]   data_out,
  output logic [1:0]          vc_out,
  output logic                idle_out,
  output logic                active_out
);
  typedef enum logic [1:0] {RESET, INIT, IDLE, ACTIVE} state_t;
  state_t              state;
  logic [WEIGHT_W-1:0] wr [4];
  logic [WEIGHT_W-1:0] credit;
  logic [1:0]          ptr, scan, gnt;
  logic [3:0]          elig;
  logic                stay, go, push_r;
  always_comb begin
    for (int i = 0; i < 4; i++) elig[i] = !fifo_empty[i] && wr[i] != '0;
    scan = ptr;
    // descending scan so the nearest eligible class after ptr wins, ptr itself last
    for (int k = 4; k >= 1; k--) if (elig[ptr + 2'(k)]) scan = ptr + 2'(k);
    stay = elig[ptr] && credit < wr[ptr];
    gnt  = stay ? ptr : scan;
    go   = state == ACTIVE && !init && !reset && !almost_full_out && |elig;
    pop  = go ? 4'b0001 << gnt : 4'b0000;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RESET;
      ptr    <= '0;
      credit <= '0;
      push_r <= 1'b0;
      for (int i = 0; i < 4; i++) wr[i] <= WEIGHT_W'(1);
    end else begin
      push_r <= go;
      if (go) begin
        ptr    <= gnt;
        credit <= stay ? credit + 1'b1 : WEIGHT_W'(1);
      end
      if (state == RESET) state <= INIT;
      else if (init) begin
        state  <= INIT;
        credit <= '0;
        wr[0]  <= weight0;
        wr[1]  <= weight1;
        wr[2]  <= weight2;
        wr[3]  <= weight3;
      end else state <= |elig ? ACTIVE : IDLE;
    end
  end
  // ptr always holds the class of the last pop, so it doubles as the registered select
  assign push_out   = push_r && !reset;
  assign vc_out     = ptr;
  assign idle_out   = state == IDLE;
  assign active_out = state == ACTIVE;
  always_comb
    data_out = !push_out ? '0 : ptr == 2'd0 ? fifo_data0 : ptr == 2'd1 ? fifo_data1 :
               ptr == 2'd2 ? fifo_data2 : fifo_data3;
endmodule
